// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : micro_sequencer
//  Purpose  : Micro-program address sequencer with two programmable opcode
//             dispatch tables, a sequential increment path and a saturating
//             count of dispatch misses.
//  Revision : 1.0  initial release
//
//  Ports
//    clk          in   1        sole clock, rising edge
//    rst_n        in   1        asynchronous active-low reset
//    stall        in   1        hold micro-PC and miss counter this cycle
//    addr_ctl     in   2        00 fetch, 01 dispatch1, 10 dispatch2, 11 seq
//    op           in   OP_W     opcode for dispatch lookup
//    cfg_we       in   1        dispatch-table write strobe
//    cfg_tbl      in   1        0 = dispatch1, 1 = dispatch2
//    cfg_idx      in   log2(N)  entry index to write
//    cfg_op       in   OP_W     entry opcode
//    cfg_target   in   UADDR_W  entry target micro-address
//    cfg_valid    in   1        entry valid bit
//    upc          out  UADDR_W  current micro-PC (registered)
//    illegal_op   out  1        one-cycle pulse after a dispatch miss
//    illegal_cnt  out  8        saturating dispatch-miss count
// ============================================================================
module micro_sequencer #(
    parameter int UADDR_W = 4,
    parameter int OP_W    = 6,
    parameter int N_ENT   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic [1:0]               addr_ctl,
    input  logic [OP_W-1:0]          op,
    input  logic                     cfg_we,
    input  logic                     cfg_tbl,
    input  logic [$clog2(N_ENT)-1:0] cfg_idx,
    input  logic [OP_W-1:0]          cfg_op,
    input  logic [UADDR_W-1:0]       cfg_target,
    input  logic                     cfg_valid,
    output logic [UADDR_W-1:0]       upc,
    output logic                     illegal_op,
    output logic [7:0]               illegal_cnt
);

    localparam logic [1:0] c_ACTL_FETCH = 2'b00;
    localparam logic [1:0] c_ACTL_D1    = 2'b01;
    localparam logic [1:0] c_ACTL_D2    = 2'b10;
    localparam logic [1:0] c_ACTL_SEQ   = 2'b11;

    // Reset contents of the dispatch tables. Values wider than the
    // configured field widths are truncated by the casts at the use site.
    function automatic int def1_op(input int i);
        case (i)
            0:       return 2;
            1:       return 4;
            2:       return 0;
            3:       return 35;
            4:       return 43;
            default: return 0;
        endcase
    endfunction

    function automatic int def1_tgt(input int i);
        case (i)
            0:       return 9;
            1:       return 8;
            2:       return 6;
            3:       return 2;
            4:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int def2_op(input int i);
        case (i)
            0:       return 35;
            1:       return 43;
            default: return 0;
        endcase
    endfunction

    function automatic int def2_tgt(input int i);
        case (i)
            0:       return 3;
            1:       return 5;
            default: return 0;
        endcase
    endfunction

    // Dispatch table storage
    logic                r_d1_valid [N_ENT];
    logic [OP_W-1:0]     r_d1_op    [N_ENT];
    logic [UADDR_W-1:0]  r_d1_tgt   [N_ENT];
    logic                r_d2_valid [N_ENT];
    logic [OP_W-1:0]     r_d2_op    [N_ENT];
    logic [UADDR_W-1:0]  r_d2_tgt   [N_ENT];

    logic [UADDR_W-1:0]  r_upc;
    logic                r_illegal_op;
    logic [7:0]          r_illegal_cnt;

    logic                w_d1_hit;
    logic [UADDR_W-1:0]  w_d1_tgt;
    logic                w_d2_hit;
    logic [UADDR_W-1:0]  w_d2_tgt;
    logic [UADDR_W-1:0]  w_next_upc;
    logic                w_miss;

    // Priority lookup: scanning from the top index down lets the lowest
    // matching index overwrite any higher match, so it wins.
    always_comb begin
        w_d1_hit = 1'b0;
        w_d1_tgt = '0;
        w_d2_hit = 1'b0;
        w_d2_tgt = '0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (r_d1_valid[i] && (r_d1_op[i] == op)) begin
                w_d1_hit = 1'b1;
                w_d1_tgt = r_d1_tgt[i];
            end
            if (r_d2_valid[i] && (r_d2_op[i] == op)) begin
                w_d2_hit = 1'b1;
                w_d2_tgt = r_d2_tgt[i];
            end
        end
    end

    // Next-address selection; a miss yields target 0 from the lookup.
    always_comb begin
        w_next_upc = '0;
        w_miss     = 1'b0;
        case (addr_ctl)
            c_ACTL_FETCH: w_next_upc = '0;
            c_ACTL_D1: begin
                w_next_upc = w_d1_tgt;
                w_miss     = ~w_d1_hit;
            end
            c_ACTL_D2: begin
                w_next_upc = w_d2_tgt;
                w_miss     = ~w_d2_hit;
            end
            c_ACTL_SEQ:   w_next_upc = r_upc + UADDR_W'(1);
            default:      w_next_upc = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upc         <= '0;
            r_illegal_op  <= 1'b0;
            r_illegal_cnt <= 8'd0;
            for (int i = 0; i < N_ENT; i++) begin
                r_d1_valid[i] <= (i < 5);
                r_d1_op[i]    <= OP_W'(def1_op(i));
                r_d1_tgt[i]   <= UADDR_W'(def1_tgt(i));
                r_d2_valid[i] <= (i < 2);
                r_d2_op[i]    <= OP_W'(def2_op(i));
                r_d2_tgt[i]   <= UADDR_W'(def2_tgt(i));
            end
        end else begin
            // Table writes are independent of stall; the lookup above
            // sees the pre-write contents for this edge.
            if (cfg_we) begin
                if (!cfg_tbl) begin
                    r_d1_valid[cfg_idx] <= cfg_valid;
                    r_d1_op[cfg_idx]    <= cfg_op;
                    r_d1_tgt[cfg_idx]   <= cfg_target;
                end else begin
                    r_d2_valid[cfg_idx] <= cfg_valid;
                    r_d2_op[cfg_idx]    <= cfg_op;
                    r_d2_tgt[cfg_idx]   <= cfg_target;
                end
            end

            if (stall) begin
                r_illegal_op <= 1'b0;
            end else begin
                r_upc        <= w_next_upc;
                r_illegal_op <= w_miss;
                if (w_miss && (r_illegal_cnt != 8'hFF)) begin
                    r_illegal_cnt <= r_illegal_cnt + 8'd1;
                end
            end
        end
    end

    assign upc         = r_upc;
    assign illegal_op  = r_illegal_op;
    assign illegal_cnt = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_micro_sequencer
//  Purpose  : Scoreboard bench for micro_sequencer. Stimulus drives inputs on
//             the falling edge and pushes the expected post-edge outputs from
//             a table-level reference model; a monitor pops and compares
//             after every rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_micro_sequencer;

    localparam int UADDR_W = 4;
    localparam int OP_W    = 6;
    localparam int N_ENT   = 8;
    localparam int IDX_W   = $clog2(N_ENT);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               stall = 1'b0;
    logic [1:0]         addr_ctl = 2'b00;
    logic [OP_W-1:0]    op = '0;
    logic               cfg_we = 1'b0;
    logic               cfg_tbl = 1'b0;
    logic [IDX_W-1:0]   cfg_idx = '0;
    logic [OP_W-1:0]    cfg_op = '0;
    logic [UADDR_W-1:0] cfg_target = '0;
    logic               cfg_valid = 1'b0;
    logic [UADDR_W-1:0] upc;
    logic               illegal_op;
    logic [7:0]         illegal_cnt;

    micro_sequencer #(
        .UADDR_W (UADDR_W),
        .OP_W    (OP_W),
        .N_ENT   (N_ENT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .addr_ctl    (addr_ctl),
        .op          (op),
        .cfg_we      (cfg_we),
        .cfg_tbl     (cfg_tbl),
        .cfg_idx     (cfg_idx),
        .cfg_op      (cfg_op),
        .cfg_target  (cfg_target),
        .cfg_valid   (cfg_valid),
        .upc         (upc),
        .illegal_op  (illegal_op),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int op;
        int tgt;
    } ent_t;

    typedef struct {
        int upc;
        int ill;
        int cnt;
    } exp_t;

    ent_t t1 [N_ENT];
    ent_t t2 [N_ENT];
    int   m_upc;
    int   m_cnt;
    exp_t exp_q [$];

    int tests = 0;
    int fails = 0;

    function automatic void model_reset();
        for (int i = 0; i < N_ENT; i++) begin
            t1[i] = '{0, 0, 0};
            t2[i] = '{0, 0, 0};
        end
        t1[0] = '{1, 2, 9};
        t1[1] = '{1, 4, 8};
        t1[2] = '{1, 0, 6};
        t1[3] = '{1, 35, 2};
        t1[4] = '{1, 43, 2};
        t2[0] = '{1, 35, 3};
        t2[1] = '{1, 43, 5};
        m_upc = 0;
        m_cnt = 0;
    endfunction

    // First valid entry with a matching opcode, else miss with target 0.
    function automatic void lookup(input bit which, input int o,
                                   output bit hit, output int tgt);
        hit = 0;
        tgt = 0;
        for (int i = 0; i < N_ENT; i++) begin
            ent_t e;
            e = which ? t2[i] : t1[i];
            if (!hit && e.v && e.op == o) begin
                hit = 1;
                tgt = e.tgt;
            end
        end
    endfunction

    // One clock of stimulus: drive at the falling edge, predict the state
    // after the next rising edge and queue it.
    task automatic step(input bit st, input int ac, input int o,
                        input bit we, input bit tb, input int ix,
                        input int co, input int ct, input bit cv);
        bit hit;
        int tgt;
        int ill;
        @(negedge clk);
        rst_n      = 1'b1;
        stall      = st;
        addr_ctl   = 2'(ac);
        op         = OP_W'(o);
        cfg_we     = we;
        cfg_tbl    = tb;
        cfg_idx    = IDX_W'(ix);
        cfg_op     = OP_W'(co);
        cfg_target = UADDR_W'(ct);
        cfg_valid  = cv;
        ill = 0;
        if (!st) begin
            case (ac)
                0: m_upc = 0;
                1: begin lookup(0, o, hit, tgt); m_upc = tgt; ill = !hit; end
                2: begin lookup(1, o, hit, tgt); m_upc = tgt; ill = !hit; end
                default: m_upc = (m_upc + 1) % (1 << UADDR_W);
            endcase
            if (ill != 0 && m_cnt < 255) m_cnt++;
        end
        if (we) begin
            if (!tb) t1[ix] = '{cv, co, ct};
            else     t2[ix] = '{cv, co, ct};
        end
        exp_q.push_back('{m_upc, ill, m_cnt});
    endtask

    task automatic go(input bit st, input int ac, input int o);
        step(st, ac, o, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset dropped between clock edges, with a table write in flight.
    task automatic do_reset(input int n);
        @(posedge clk);
        #3;
        rst_n      = 1'b0;
        cfg_we     = 1'b1;
        cfg_tbl    = 1'b0;
        cfg_idx    = '0;
        cfg_op     = 6'd63;
        cfg_target = 4'd15;
        cfg_valid  = 1'b1;
        #1;
        tests++;
        if (upc !== '0 || illegal_op !== 1'b0 || illegal_cnt !== 8'd0) begin
            fails++;
            $display("FAIL async_reset: upc=%0d ill=%0d cnt=%0d required 0/0/0",
                     upc, illegal_op, illegal_cnt);
        end
        model_reset();
        repeat (n) begin
            @(negedge clk);
            exp_q.push_back('{0, 0, 0});
        end
    endtask

    // Monitor: compare after every rising edge that has a queued prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                tests++;
                if (upc !== UADDR_W'(e.upc) || illegal_op !== 1'(e.ill) ||
                    illegal_cnt !== 8'(e.cnt)) begin
                    fails++;
                    $display("FAIL cycle@%0t: upc=%0d ill=%0d cnt=%0d required %0d/%0d/%0d",
                             $time, upc, illegal_op, illegal_cnt, e.upc, e.ill, e.cnt);
                end
            end
        end
    end

    int pool [8] = '{0, 2, 4, 7, 35, 43, 63, 12};

    task automatic random_phase(input int n);
        for (int k = 0; k < n; k++) begin
            bit st;
            bit we;
            st = ($urandom_range(0, 4) == 0);
            we = ($urandom_range(0, 7) == 0);
            step(st, $urandom_range(0, 3), pool[$urandom_range(0, 7)],
                 we, 1'($urandom_range(0, 1)), $urandom_range(0, N_ENT - 1),
                 pool[$urandom_range(0, 7)], $urandom_range(0, 15),
                 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        model_reset();
        do_reset(2);

        // Sequential x3 then dispatch1 op=35
        go(0, 3, 0); go(0, 3, 0); go(0, 3, 0);
        go(0, 1, 35);
        // dispatch2 op=43, dispatch1 op=4, fetch
        go(0, 2, 43); go(0, 1, 4); go(0, 0, 0);
        // Miss pulse
        go(0, 1, 63); go(0, 3, 0);
        // Climb to 15 and wrap
        go(0, 0, 0);
        repeat (15) go(0, 3, 0);
        go(0, 3, 0);
        // Stall holds with a dispatch request present
        go(0, 3, 0); go(0, 3, 0);
        repeat (3) go(1, 1, 2);
        go(1, 1, 63);
        // Same-cycle write is not visible to this lookup
        step(0, 1, 7, 1, 0, 5, 7, 12, 1);
        go(0, 1, 7);
        // Invalidate idx 3, then op=35 misses
        step(0, 3, 0, 1, 0, 3, 35, 2, 0);
        go(0, 1, 35);
        // Write during stall still lands
        step(1, 2, 7, 1, 1, 7, 7, 11, 1);
        go(0, 2, 7);
        // Duplicate opcode: lowest index wins
        step(0, 0, 0, 1, 1, 2, 7, 4, 1);
        go(0, 2, 7);

        random_phase(400);

        // Saturation of the miss counter
        do_reset(1);
        repeat (300) go(0, 1, 63);
        go(0, 3, 0);

        // Reset while upc=9, then read defaults back through dispatch
        go(0, 1, 2);
        do_reset(2);
        go(0, 1, 2);  go(0, 1, 4);  go(0, 1, 0);
        go(0, 1, 35); go(0, 1, 43); go(0, 1, 63);
        go(0, 2, 35); go(0, 2, 43); go(0, 2, 2);

        random_phase(300);

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The block SHALL provide parameter UADDR_W, default 4, giving the micro-address width.
REQ-002 The block SHALL provide parameter OP_W, default 6, giving the opcode width.
REQ-003 The block SHALL provide parameter N_ENT, default 8 (power of 2, at least 2), giving the entries per dispatch table.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 stall  in  1  hold the micro-PC and counters this cycle.
REQ-007 addr_ctl  in  2  next-address select: 00 fetch, 01 dispatch1, 10 dispatch2, 11 sequential.
REQ-008 op  in  OP_W  opcode used for dispatch lookup.
REQ-009 cfg_we  in  1  dispatch-table write strobe.
REQ-010 cfg_tbl  in  1  table select: 0 is dispatch1, 1 is dispatch2.
REQ-011 cfg_idx  in  log2(N_ENT)  entry index to write.
REQ-012 cfg_op, cfg_target, cfg_valid  in  OP_W, UADDR_W, 1  entry contents.
REQ-013 upc  out  UADDR_W  current micro-PC, registered.
REQ-014 illegal_op  out  1  one-cycle registered pulse on a dispatch miss.
REQ-015 illegal_cnt  out  8  saturating count of dispatch misses.

Function
REQ-016 Each table entry SHALL hold {valid, op, target}.
REQ-017 Lookup SHALL be combinational: the lowest-index valid entry with op equal to the input op wins.
REQ-018 A lookup with no matching entry SHALL be a miss with target 0.
REQ-019 When stall is 0, the block SHALL load upc on the clock edge as follows:
- fetch: 0
- dispatch1: dispatch1 lookup target
- dispatch2: dispatch2 lookup target
- sequential: (upc+1) mod 2^UADDR_W, with wrap from all-ones to 0 and no flag
REQ-020 When stall is 1, the block SHALL hold upc and illegal_cnt, force illegal_op to 0, and ignore addr_ctl and op.
REQ-021 illegal_op SHALL be 1 in the cycle after an unstalled edge at which addr_ctl selected a dispatch and the lookup missed, and 0 otherwise.
REQ-022 illegal_cnt SHALL increment on each such miss and saturate at 255.
REQ-023 A cfg_we write SHALL update the addressed entry at the clock edge regardless of stall.
REQ-024 A lookup in the same cycle as a write SHALL use the pre-write contents; the new contents SHALL be visible from the following cycle.
REQ-025 A write with cfg_valid=0 SHALL disable the entry; its op and target bits are then don't-care.
REQ-026 Duplicate valid opcodes in a table SHALL be legal, with the lowest index taking priority.
REQ-027 Opcodes beyond the N_ENT-th configured entry SHALL be reachable only by rewriting an entry.

Reset
REQ-028 While rst_n is 0, the block SHALL immediately force upc=0, illegal_op=0 and illegal_cnt=0, independent of clk.
REQ-029 Reset SHALL load dispatch1 entries 0..4 with (op, target) = (2,9), (4,8), (0,6), (35,2), (43,2), all valid, and all other entries invalid.
REQ-030 Reset SHALL load dispatch2 entries 0..1 with (35,3) and (43,5), both valid, and all other entries invalid.
REQ-031 Defaults needing more than UADDR_W bits SHALL be truncated, since UADDR_W below 4 is permitted only with reconfiguration.
REQ-032 Reset asserted mid-operation, including during a cfg write, SHALL discard the write and restore the defaults.
REQ-033 The first unstalled edge after rst_n rises SHALL act on addr_ctl normally.

Verification
REQ-034 Reset, then sequential x3, then dispatch1 with op=35: upc goes 0,1,2,3, then 2.
REQ-035 From upc=2, dispatch2 with op=43: upc=5; dispatch1 with op=4: upc=8; fetch: upc=0.
REQ-036 Dispatch1 with op=63: upc=0, illegal_op pulses for 1 cycle, illegal_cnt goes 0 to 1; 300 consecutive misses leave illegal_cnt=255.
REQ-037 At upc=15 (UADDR_W=4), sequential: upc=0, no illegal_op. With stall=1 and addr_ctl=01, op=2: upc holds for 3 cycles and illegal_cnt is unchanged.
REQ-038 Same-cycle cfg write to dispatch1 idx 5 of (7,12) plus dispatch1 with op=7: miss and upc=0; next dispatch1 with op=7: upc=12. Writing idx 3 invalid, then op=35 gives a miss.
REQ-039 Drop rst_n between clock edges while upc=9: upc=0 immediately; all tables read back as the defaults through the dispatch results.
